// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// ----------------------------------------------------------------------------
// Two-client arbiter in front of a single-request memory controller.
//   Port A : instruction fetch, read-only.
//   Port B : data access, read or write.
// One transaction is in flight at a time. Each transaction walks through
// IDLE -> BUSY -> RELEASE -> IDLE. The granted port's done output pulses
// during the RELEASE cycle.
//
// Configuration macro:
//   MEM_ARBITER_ROUND_ROBIN_EN
//     - Undefined (default): port B always wins a tie.
//     - Defined: a tie goes to the port that did not win the previous grant,
//       as recorded in last_grant. last_grant resets to A, so the first tie
//       after reset is granted to B.
//
// Ports:
//   clk                  : single clock; all state updates on the rising edge
//   rst                  : synchronous, active-high reset; overrides ena
//   ena                  : clock enable; when low, every register holds
//   a_req / a_addr       : port A request level and read address
//   a_rdata / a_done     : port A read data and one-cycle completion pulse
//   b_req / b_addr       : port B request level and address
//   b_wdata / b_we       : port B write data and write enable (1 = write)
//   b_rdata / b_done     : port B read data and one-cycle completion pulse
//   mem_request          : request level to the controller
//   mem_address          : latched address for the controller
//   mem_write_value      : latched write data (0 for port A)
//   mem_write_enable     : latched write enable (0 for port A)
//   mem_read_value       : read data returned by the controller
//   mem_request_complete : controller completion indication
//   busy                 : high while in BUSY or RELEASE
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,

    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [WORD_W-1:0] a_rdata,
    output logic              a_done,

    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WORD_W-1:0] b_wdata,
    input  logic              b_we,
    output logic [WORD_W-1:0] b_rdata,
    output logic              b_done,

    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_write_value,
    output logic              mem_write_enable,
    input  logic [WORD_W-1:0] mem_read_value,
    input  logic              mem_request_complete,

    output logic              busy
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0] state;

    // Which client owns the outstanding transaction (1 = port B).
    logic grant_b;

    // Grant decision for the current IDLE cycle (1 = port B).
    logic grant_b_next;

    // Any client asking for service this cycle.
    logic any_req;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Port that won the most recent grant (1 = B). Resets to A so that the
    // first tie after reset goes to B.
    logic last_grant;
`endif

    assign any_req = a_req | b_req;

    // Grant selection. A lone requester always wins. On a tie the default
    // build favours port B so data accesses never wait behind fetches; the
    // round-robin build alternates by handing the tie to whichever port did
    // not win last time.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        grant_b_next = b_req;
        if (a_req && b_req) begin
            grant_b_next = ~last_grant;
        end
    end
`else
    always_comb begin
        grant_b_next = b_req;
    end
`endif

    // busy covers both the wait for the controller and the release cycle,
    // so a client can see that the arbiter is not ready to accept yet.
    assign busy = (state == ST_BUSY) || (state == ST_RELEASE);

    // Main FSM and datapath. Reset wins over ena. With ena low nothing
    // moves, which also stretches a done pulse so that it still spans
    // exactly one enabled cycle. The request is captured in IDLE and the
    // controller-facing outputs stay frozen through BUSY, so clients may
    // change their inputs freely once granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            grant_b          <= 1'b0;
            mem_request      <= 1'b0;
            mem_address      <= '0;
            mem_write_value  <= '0;
            mem_write_enable <= 1'b0;
            a_rdata          <= '0;
            b_rdata          <= '0;
            a_done           <= 1'b0;
            b_done           <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_grant       <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    if (any_req) begin
                        grant_b     <= grant_b_next;
                        mem_request <= 1'b1;
                        state       <= ST_BUSY;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_grant  <= grant_b_next;
`endif
                        if (grant_b_next) begin
                            mem_address      <= b_addr;
                            mem_write_value  <= b_wdata;
                            mem_write_enable <= b_we;
                        end else begin
                            // Port A is fetch-only: never present write data.
                            mem_address      <= a_addr;
                            mem_write_value  <= '0;
                            mem_write_enable <= 1'b0;
                        end
                    end
                end

                ST_BUSY: begin
                    if (mem_request_complete) begin
                        mem_request <= 1'b0;
                        state       <= ST_RELEASE;
                        if (grant_b) begin
                            b_done <= 1'b1;
                            // A write leaves the last read result intact.
                            if (!mem_write_enable) begin
                                b_rdata <= mem_read_value;
                            end
                        end else begin
                            a_done  <= 1'b1;
                            a_rdata <= mem_read_value;
                        end
                    end
                end

                ST_RELEASE: begin
                    // One dead cycle with the request low; requests seen
                    // here are deliberately ignored.
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    a_done      <= 1'b0;
                    b_done      <= 1'b0;
                    mem_request <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, address width.
REQ-002 SHALL have parameter WORD_W, default 16, data word width.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port ena, input, 1: enable; when low, all registers hold their values.
REQ-006 SHALL have the port A (fetch, read-only) ports:
- a_req, input, 1: request level.
- a_addr, input, ADDR_W: read address.
- a_rdata, output, WORD_W: read data.
- a_done, output, 1: completion pulse.
REQ-007 SHALL have the port B (data) ports:
- b_req, input, 1: request level.
- b_addr, input, ADDR_W: address.
- b_wdata, input, WORD_W: write data.
- b_we, input, 1: 1 = write, 0 = read.
- b_rdata, output, WORD_W: read data.
- b_done, output, 1: completion pulse.
REQ-008 SHALL have the memory controller ports:
- mem_request, output, 1: request level.
- mem_address, output, ADDR_W: address.
- mem_write_value, output, WORD_W: write data.
- mem_write_enable, output, 1: write enable.
- mem_read_value, input, WORD_W: read data.
- mem_request_complete, input, 1: controller completion.
REQ-009 SHALL have port busy, output, 1: high in BUSY and RELEASE.

Function
REQ-010 SHALL implement states IDLE, BUSY and RELEASE as an FSM.
REQ-011 IDLE: SHALL sample a_req and b_req.
- If either is high, SHALL register the grant and latch the granted port's address, wdata and we into mem_address, mem_write_value and mem_write_enable.
- SHALL then set mem_request=1 and go to BUSY at the next edge.
REQ-012 For a port A grant, SHALL drive mem_write_enable=0 and mem_write_value=0.
REQ-013 BUSY: SHALL hold mem_request=1 and the latched outputs stable until mem_request_complete=1.
REQ-014 On the BUSY edge with mem_request_complete=1:
- If the granted port reads, SHALL latch mem_read_value into that port's rdata.
- SHALL set mem_request=0, pulse the granted port's done for exactly one cycle (the RELEASE cycle), and go to RELEASE.
REQ-015 RELEASE: SHALL keep mem_request=0 for exactly one cycle, then go to IDLE; a_req and b_req are ignored in this state.
REQ-016 A client still holding req in the IDLE cycle after its done pulse SHALL be treated as a new transaction.
REQ-017 rdata SHALL hold its value until that port's next completed read; a write SHALL leave b_rdata unchanged.
REQ-018 Timing: best-case turnaround from req high in IDLE to done is 2 cycles + controller latency; minimum spacing between back-to-back transactions is 3 cycles.
REQ-019 Inputs changing during BUSY SHALL NOT affect the outstanding transaction.
REQ-020 When ena=0, state, outputs and pulses SHALL freeze; a done pulse frozen this way SHALL still last exactly one enabled cycle.
REQ-021 Tie rule without ROUND_ROBIN_EN: port B SHALL win when a_req and b_req are both high in IDLE.

Reset
REQ-022 rst=1 SHALL force, at the next edge (regardless of ena):
- state=IDLE, mem_request=0, mem_address=0, mem_write_value=0, mem_write_enable=0.
- a_rdata=0, b_rdata=0, a_done=0, b_done=0, busy=0.
- last_grant=A.
REQ-023 Reset during BUSY or RELEASE SHALL abandon the transaction with no done pulse.

Configuration
REQ-024 Macro MEM_ARBITER_ROUND_ROBIN_EN, when defined, SHALL resolve ties against the port recorded in last_grant (updated on every grant), so the first tie after reset grants B.
REQ-025 When MEM_ARBITER_ROUND_ROBIN_EN is undefined, fixed B priority per REQ-021 SHALL apply and the last_grant register SHALL NOT exist.

Verification
REQ-026 Port A read: a_req=1, a_addr=0x00123; controller model returns 0xBEEF after 48 cycles -> mem_request high with mem_address=0x00123 and mem_write_enable=0, then a_rdata=0xBEEF with a_done high for 1 cycle.
REQ-027 Port B write: b_addr=0x1FFFF, b_wdata=0xA5A5, b_we=1 -> mem_write_value=0xA5A5, mem_write_enable=1, b_done pulses once, b_rdata unchanged.
REQ-028 Tie, fixed priority: a_req and b_req both high for 3 transactions -> grants B, B, B; A starves while b_req stays high.
REQ-029 Tie with MEM_ARBITER_ROUND_ROBIN_EN: both held high -> grants B, A, B, A; each mem_request preceded by exactly one low RELEASE cycle.
REQ-030 Reset in BUSY: rst=1 on the 10th BUSY cycle -> next edge mem_request=0, state IDLE, no a_done or b_done, rdata=0.
REQ-031 ena=0 for 5 cycles during the RELEASE cycle -> done stays high throughout, then lasts 1 enabled cycle; no extra transaction is issued.
